// File: rtl/virtual_host_sync.sv
// ---------------------------------------------------------------------------
// virtual_host_sync
//
// Traffic endpoint at one edge port of the synchronous cast/gather network.
// The TX side injects the numbered flit stream 0,1,2,... into a cast input.
// The RX side drains the gather stream and checks that every flit comes back
// in order and unmodified. It then reports completion, or completion with
// an error.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-high
//   start           one-cycle pulse that begins a run from IDLE or DONE
//   cast_data_o     TX payload: the sequence number of the flit on offer
//   cast_valid_o    TX valid; it depends only on registered state
//   cast_ready_i    TX ready from the network
//   gather_data_i   RX payload
//   gather_valid_i  RX valid
//   gather_ready_o  RX ready: armed in SEND/DRAIN, optionally LFSR-throttled
//   sent_cnt        TX handshakes completed in this run
//   recv_cnt        RX handshakes completed in this run
//   busy            high in SEND or DRAIN
//   done            high in DONE until the next start or reset
//   err             sticky flag: payload mismatch, overflow or drain timeout
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef DW
`define DW 16
`endif

module virtual_host_sync #(
    parameter int unsigned NUM_FLITS = 10000,
    parameter int unsigned GAP       = 0,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [`DW-1:0]   cast_data_o,
    output logic             cast_valid_o,
    input  logic             cast_ready_i,
    input  logic [`DW-1:0]   gather_data_i,
    input  logic             gather_valid_i,
    output logic             gather_ready_o,
    output logic [31:0]      sent_cnt,
    output logic [31:0]      recv_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [31:0]     r_sent;
    logic [31:0]     r_recv;
    logic            r_err;
    logic [GW-1:0]   r_gap;
    logic [31:0]     r_timeout;
    logic [15:0]     r_lfsr;

    logic            w_armed;
    logic            w_txFire;
    logic            w_rxFire;
    logic            w_rxBad;
    logic            w_startRun;
    logic            w_timeoutHit;
    logic            w_lfsrFb;
    logic [31:0]     w_recvNext;

    // TX valid comes only from the state and the gap counter, so the
    // network's ready can never ripple back into our valid. The payload is
    // the running send count, which only moves on a handshake and therefore
    // stays stable while the network stalls us.
    assign cast_valid_o   = (r_state == ST_SEND) && (r_gap == '0);
    assign cast_data_o    = cast_valid_o ? r_sent[`DW-1:0] : '0;

    // The RX side is armed for the whole run, so returning flits can
    // overlap injection.
    assign w_armed        = (r_state == ST_SEND) || (r_state == ST_DRAIN);
    assign gather_ready_o = w_armed && (STALL_EN ? r_lfsr[0] : 1'b1);

    assign w_txFire       = cast_valid_o && cast_ready_i;
    assign w_rxFire       = gather_valid_i && gather_ready_o;
    assign w_recvNext     = r_recv + {31'd0, w_rxFire};

    // A returning flit is bad if its payload is not the next expected
    // sequence number. It is also bad if accepting it would leave more
    // flits received than sent, counting a send that completes in the
    // same cycle.
    assign w_rxBad        = (gather_data_i != r_recv[`DW-1:0]) ||
                            (r_recv >= (r_sent + {31'd0, w_txFire}));

    // Fibonacci form of x^16+x^14+x^13+x^11, shifting towards bit 0.
    assign w_lfsrFb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    assign sent_cnt       = r_sent;
    assign recv_cnt       = r_recv;
    assign err            = r_err;
    assign busy           = w_armed;
    assign done           = (r_state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. DRAIN completes on the cycle of the final RX
    // handshake, so done follows that handshake by one cycle. If the last
    // flit was already back when DRAIN was entered, it completes after one
    // DRAIN cycle. The timeout fires only on a cycle with no RX handshake,
    // after TIMEOUT consecutive quiet DRAIN cycles.
    always_comb begin
        w_stateNext  = r_state;
        w_startRun   = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_stateNext = ST_SEND;
                    w_startRun  = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_txFire && ((r_sent + 32'd1) == NUM_FLITS)) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_recvNext >= NUM_FLITS) begin
                    w_stateNext = ST_DONE;
                end else if (!w_rxFire && (r_timeout == (TIMEOUT - 1))) begin
                    w_stateNext  = ST_DONE;
                    w_timeoutHit = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Run counters, error flag, gap and timeout counters. A start clears
    // everything belonging to the previous run on the same edge that
    // enters SEND. The LFSR is deliberately not reseeded by start, so the
    // throttle pattern keeps running across back-to-back runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent    <= '0;
            r_recv    <= '0;
            r_err     <= 1'b0;
            r_gap     <= '0;
            r_timeout <= '0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            if (w_armed) begin
                r_lfsr <= {w_lfsrFb, r_lfsr[15:1]};
            end
            if (w_startRun) begin
                r_sent    <= '0;
                r_recv    <= '0;
                r_err     <= 1'b0;
                r_gap     <= '0;
                r_timeout <= '0;
            end else begin
                if (w_txFire) begin
                    r_sent <= r_sent + 32'd1;
                    r_gap  <= GW'(GAP);
                end else if (r_gap != '0) begin
                    r_gap <= r_gap - GW'(1);
                end
                if (w_rxFire) begin
                    r_recv <= r_recv + 32'd1;
                    if (w_rxBad) begin
                        r_err <= 1'b1;
                    end
                end
                if (w_timeoutHit) begin
                    r_err <= 1'b1;
                end
                if (r_state == ST_DRAIN) begin
                    r_timeout <= w_rxFire ? 32'd0 : (r_timeout + 32'd1);
                end else begin
                    r_timeout <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_virtual_host_sync.sv
`timescale 1ns/1ps
`ifndef DW
`define DW 16
`endif

module tb_virtual_host_sync;

    localparam int          NUM  = 16;
    localparam int          TO   = 32;
    localparam int          GAPB = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          X    = 2;
    localparam int          Y    = 3;

    typedef struct {
        int sent;
        int recv;
        int err;
        int lat;
        int errCycle;
    } res_t;

    logic clk = 1'b0;
    logic rst, start, rstB, startB;

    logic [`DW-1:0] castDataA, gatherDataA;
    logic           castValidA, castReadyA, gatherValidA, gatherReadyA;
    logic [31:0]    sentA, recvA;
    logic           busyA, doneA, errA;

    logic [`DW-1:0] castDataB, gatherDataB;
    logic           castValidB, castReadyB, gatherValidB, gatherReadyB;
    logic [31:0]    sentB, recvB;
    logic           busyB, doneB, errB;

    int compared   = 0;
    int mismatched = 0;

    int netMode    = 0;
    int corruptSeq = -1;
    int dropSeq    = -1;

    res_t           resExp[$];
    logic [`DW-1:0] txExp[$];

    logic [`DW-1:0] fifoMem [2];
    logic           fifoWr, fifoRd, toggle;
    logic [1:0]     fifoCnt;
    logic           fifoPush, fifoPop;

    always #5 clk = ~clk;

    virtual_host_sync #(
        .NUM_FLITS(NUM), .GAP(0), .STALL_EN(1'b0), .LFSR_SEED(SEED), .TIMEOUT(TO)
    ) dutA (
        .clk(clk), .rst(rst), .start(start),
        .cast_data_o(castDataA), .cast_valid_o(castValidA), .cast_ready_i(castReadyA),
        .gather_data_i(gatherDataA), .gather_valid_i(gatherValidA), .gather_ready_o(gatherReadyA),
        .sent_cnt(sentA), .recv_cnt(recvA), .busy(busyA), .done(doneA), .err(errA)
    );

    virtual_host_sync #(
        .NUM_FLITS(NUM), .GAP(GAPB), .STALL_EN(1'b1), .LFSR_SEED(SEED), .TIMEOUT(TO)
    ) dutB (
        .clk(clk), .rst(rstB), .start(startB),
        .cast_data_o(castDataB), .cast_valid_o(castValidB), .cast_ready_i(castReadyB),
        .gather_data_i(gatherDataB), .gather_valid_i(gatherValidB), .gather_ready_o(gatherReadyB),
        .sent_cnt(sentB), .recv_cnt(recvB), .busy(busyB), .done(doneB), .err(errB)
    );

    // Instance B: straight loopback, with TX ready taken from RX ready so
    // every TX handshake is also an RX handshake.
    assign castReadyB   = gatherReadyB;
    assign gatherValidB = castValidB;
    assign gatherDataB  = castDataB;

    // Instance A network: direct loopback with optional corruption or drop
    // of one sequence number, or a 2-deep FIFO with alternating TX ready.
    always_comb begin
        castReadyA   = 1'b1;
        gatherValidA = castValidA;
        gatherDataA  = castDataA;
        if (netMode == 1) begin
            castReadyA   = toggle && (fifoCnt != 2'd2);
            gatherValidA = (fifoCnt != 2'd0);
            gatherDataA  = fifoMem[fifoRd];
        end else begin
            if (int'(castDataA) == dropSeq) gatherValidA = 1'b0;
            if (int'(castDataA) == corruptSeq) gatherDataA = castDataA ^ `DW'(1);
        end
    end

    assign fifoPush = (netMode == 1) && castValidA && castReadyA;
    assign fifoPop  = (netMode == 1) && gatherValidA && gatherReadyA;

    // Loopback FIFO and the 1010... ready pattern generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifoWr  <= 1'b0;
            fifoRd  <= 1'b0;
            fifoCnt <= 2'd0;
            toggle  <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (fifoPush) begin
                fifoMem[fifoWr] <= castDataA;
                fifoWr          <= ~fifoWr;
            end
            if (fifoPop) fifoRd <= ~fifoRd;
            if (fifoPush && !fifoPop) fifoCnt <= fifoCnt + 2'd1;
            else if (!fifoPush && fifoPop) fifoCnt <= fifoCnt - 2'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queues the expected TX stream and run result, then pulses start.
    // Called one time unit after a rising edge.
    task automatic applyStimulus(input int mode, input int corrupt, input int drop, input res_t exp);
        netMode    = mode;
        corruptSeq = corrupt;
        dropSeq    = drop;
        resExp.push_back(exp);
        for (int i = 0; i < NUM; i++) txExp.push_back(`DW'(i));
        $display("[TB] node (%0d,%0d) host start", X, Y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while (!doneA && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, doneA, 1);
        $display("[TB] node (%0d,%0d) host done err=%b", X, Y, errA);
        @(posedge clk);
        #1;
    endtask

    // Instance A monitor: pops the expected sequence on every TX
    // handshake, checks TX hold under backpressure, and checks the run
    // result on the rising edge of done.
    initial begin : monA
        int             cnt, errRise;
        logic           running, prevStall, prevDone;
        logic [`DW-1:0] prevData, expData;
        res_t           r;
        forever begin
            @(negedge clk);
            if (rst) begin
                running   = 1'b0;
                prevStall = 1'b0;
                cnt       = 0;
                errRise   = 0;
            end else begin
                if (start && !busyA) begin
                    cnt     = 0;
                    errRise = 0;
                    running = 1'b1;
                end else begin
                    cnt++;
                    if (errA && errRise == 0) errRise = cnt;
                end
                if (prevStall) begin
                    checkOutput("A.holdValid", castValidA, 1);
                    checkOutput("A.holdData", castDataA, prevData);
                end
                if (castValidA && castReadyA) begin
                    if (txExp.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL A.txExtra: got flit %0h expected none", castDataA);
                    end else begin
                        expData = txExp.pop_front();
                        checkOutput("A.txData", castDataA, expData);
                    end
                end
                prevStall = castValidA && !castReadyA;
                prevData  = castDataA;
                if (doneA && !prevDone && running) begin
                    if (resExp.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL A.doneUnexpected: got done expected none");
                    end else begin
                        r = resExp.pop_front();
                        checkOutput("A.sent", sentA, r.sent);
                        checkOutput("A.recv", recvA, r.recv);
                        checkOutput("A.err", errA, r.err);
                        if (r.lat != 0) checkOutput("A.latency", cnt, r.lat);
                        checkOutput("A.errCycle", errRise, r.errCycle);
                    end
                    running = 1'b0;
                end
            end
            prevDone = doneA;
        end
    end

    // Instance B monitor: cycle model of gap, LFSR throttle and run state.
    initial begin : monB
        logic [15:0] mLfsr;
        int          mSent, gapLeft;
        logic        sending, drainOne, mDone, armed, expValid, expReady, fire;
        forever begin
            @(negedge clk);
            if (rstB) begin
                mLfsr    = SEED;
                mSent    = 0;
                gapLeft  = 0;
                sending  = 1'b0;
                drainOne = 1'b0;
                mDone    = 1'b0;
            end else begin
                armed    = sending || drainOne;
                expValid = sending && (gapLeft == 0);
                expReady = armed && mLfsr[0];
                checkOutput("B.valid", castValidB, expValid);
                checkOutput("B.ready", gatherReadyB, expReady);
                checkOutput("B.busy", busyB, armed);
                checkOutput("B.done", doneB, mDone);
                checkOutput("B.err", errB, 0);
                checkOutput("B.sent", sentB, mSent);
                checkOutput("B.recv", recvB, mSent);
                if (expValid) checkOutput("B.data", castDataB, mSent);
                fire = expValid && expReady;
                if (armed) mLfsr = {mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5], mLfsr[15:1]};
                if (drainOne) begin
                    drainOne = 1'b0;
                    mDone    = 1'b1;
                end
                if (fire) begin
                    mSent++;
                    gapLeft = GAPB;
                    if (mSent == NUM) begin
                        sending  = 1'b0;
                        drainOne = 1'b1;
                    end
                end else if (gapLeft > 0) begin
                    gapLeft--;
                end
                if (startB && !armed) begin
                    sending = 1'b1;
                    mSent   = 0;
                    gapLeft = 0;
                    mDone   = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got no end of run expected finish within 20000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int n;
        rst    = 1'b1;
        rstB   = 1'b1;
        start  = 1'b0;
        startB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        rstB = 1'b0;

        // Reset state
        checkOutput("rst.data", castDataA, 0);
        checkOutput("rst.valid", castValidA, 0);
        checkOutput("rst.ready", gatherReadyA, 0);
        checkOutput("rst.sent", sentA, 0);
        checkOutput("rst.recv", recvA, 0);
        checkOutput("rst.busy", busyA, 0);
        checkOutput("rst.done", doneA, 0);
        checkOutput("rst.err", errA, 0);

        // Throttled RX with a 3-cycle gap (instance B)
        startB = 1'b1;
        @(posedge clk);
        #1;
        startB = 1'b0;
        n = 0;
        while (!doneB && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("B.finished", doneB, 1);
        checkOutput("B.finalSent", sentB, NUM);
        checkOutput("B.finalRecv", recvB, NUM);

        // Loopback, constant ready: done 18 cycles after start
        applyStimulus(0, -1, -1, res_t'{NUM, NUM, 0, 18, 0});
        waitDone("loopback.done", 200);

        // Backpressure through a 2-deep FIFO
        applyStimulus(1, -1, -1, res_t'{NUM, NUM, 0, 0, 0});
        waitDone("fifo.done", 200);

        // Bit 0 of the 5th returning flit flipped: err visible in cycle 6
        applyStimulus(0, 4, -1, res_t'{NUM, NUM, 1, 18, 6});
        waitDone("corrupt.done", 200);

        // Last flit lost: 32 quiet DRAIN cycles, then done with err
        applyStimulus(0, -1, 15, res_t'{NUM, NUM - 1, 1, 49, 49});
        waitDone("timeout.done", 200);

        // Reset after 7 TX flits, then a fresh run from sequence 0
        applyStimulus(0, -1, -1, res_t'{NUM, NUM, 0, 18, 0});
        n = 0;
        while (sentA < 7 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("abort.reachSeven", sentA, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.data", castDataA, 0);
        checkOutput("abort.valid", castValidA, 0);
        checkOutput("abort.ready", gatherReadyA, 0);
        checkOutput("abort.sent", sentA, 0);
        checkOutput("abort.recv", recvA, 0);
        checkOutput("abort.busy", busyA, 0);
        checkOutput("abort.done", doneA, 0);
        checkOutput("abort.err", errA, 0);
        resExp.delete();
        txExp.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, -1, -1, res_t'{NUM, NUM, 0, 18, 0});
        waitDone("restart.done", 200);

        checkOutput("A.txLeft", txExp.size(), 0);
        checkOutput("A.resLeft", resExp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
